// File: rtl/blinky_led_sequencer.sv
// PLL-lock-qualified LED sequencer: waits for a stable lock, then advances an LED pattern at TICK_HZ.
// Define BLINKY_SCANNER_EN for a bouncing one-hot scanner; the default build uses a binary counter.
module blinky_led_sequencer #(
  parameter int CLK_HZ             = 2000000,
  parameter int TICK_HZ            = 4,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int LED_W              = 10
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             locked,
  output logic [LED_W-1:0] led,
  output logic             running,
  output logic             tick,
  output logic [7:0]       lost_cnt
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int SW  = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_MAX  = PW'(DIV - 1);
  localparam logic [SW-1:0] STABLE_MAX = SW'(LOCK_STABLE_CYCLES - 1);
`ifdef BLINKY_SCANNER_EN
  localparam logic [LED_W-1:0] LED_INIT = LED_W'(1);
`else
  localparam logic [LED_W-1:0] LED_INIT = '0;
`endif

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    RUN       = 2'd1,
    LOST      = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [SW-1:0]    stable_q, stable_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic [LED_W-1:0] led_q, led_d;
  logic             dir_q, dir_d;
  logic [7:0]       lost_q, lost_d;
  logic [LED_W-1:0] led_adv;
  logic             dir_adv;
  logic             locked_s;

  assign sync_d   = {sync_q[0], locked};
  assign locked_s = sync_q[1];

`ifdef BLINKY_SCANNER_EN
  // dir_q = 0 means moving toward the MSB; end bits flip direction so they are shown only once
  always_comb begin
    led_adv = led_q;
    dir_adv = dir_q;
    if (LED_W > 1) begin
      if (!dir_q) begin
        if (led_q[LED_W-1]) begin
          dir_adv = 1'b1;
          led_adv = led_q >> 1;
        end else begin
          led_adv = led_q << 1;
        end
      end else begin
        if (led_q[0]) begin
          dir_adv = 1'b0;
          led_adv = led_q << 1;
        end else begin
          led_adv = led_q >> 1;
        end
      end
    end
  end
`else
  assign led_adv = led_q + LED_W'(1);
  assign dir_adv = dir_q;
`endif

  always_comb begin
    state_d  = state_q;
    stable_d = '0;
    presc_d  = '0;
    led_d    = led_q;
    dir_d    = dir_q;
    lost_d   = lost_q;
    case (state_q)
      WAIT_LOCK: begin
        if (locked_s) begin
          if (stable_q == STABLE_MAX) begin
            state_d = RUN;
            led_d   = LED_INIT;
            dir_d   = 1'b0;
          end else begin
            stable_d = stable_q + SW'(1);
          end
        end
      end
      RUN: begin
        // Lock loss wins over a coincident tick: the pending advance is dropped
        if (!locked_s) begin
          state_d = LOST;
          led_d   = '0;
          if (lost_q != 8'hFF) begin
            lost_d = lost_q + 8'd1;
          end
        end else if (presc_q == PRESC_MAX) begin
          led_d = led_adv;
          dir_d = dir_adv;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end
      LOST: begin
        led_d = '0;
        if (locked_s) begin
          state_d = WAIT_LOCK;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        led_d   = '0;
      end
    endcase
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= WAIT_LOCK;
      sync_q   <= '0;
      stable_q <= '0;
      presc_q  <= '0;
      led_q    <= '0;
      dir_q    <= 1'b0;
      lost_q   <= '0;
    end else begin
      state_q  <= state_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      presc_q  <= presc_d;
      led_q    <= led_d;
      dir_q    <= dir_d;
      lost_q   <= lost_d;
    end
  end

  assign led      = led_q;
  assign running  = (state_q == RUN);
  assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign lost_cnt = lost_q;

endmodule
